// File: rtl/ahb_simctl.sv
// ahb_simctl: AHB-lite simulation/debug control slave.
// Provides a TX character FIFO with a valid/ready sink, a sticky exit-code register,
// a free-running 64-bit cycle counter and scratch registers.
// Ports:
//   HCLK_I, HRESET_N_I                  clock, async active-low reset
//   HSEL_I, HREADY_I, HTRANS_I, HWRITE_I,
//   HSIZE_I, HADDR_I, HWDATA_I          AHB-lite slave request
//   HRDATA_O, HREADY_O, HRESP_O         AHB-lite slave response
//   TX_VALID_O, TX_DATA_O, TX_READY_I   character sink handshake
//   EXIT_VALID_O, EXIT_CODE_O           sticky exit status
module ahb_simctl #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter logic [31:0] ID_VALUE    = 32'h51C7_0001
) (
  input  logic        HCLK_I,
  input  logic        HRESET_N_I,
  input  logic        HSEL_I,
  input  logic        HREADY_I,
  input  logic [1:0]  HTRANS_I,
  input  logic        HWRITE_I,
  input  logic [2:0]  HSIZE_I,
  input  logic [11:0] HADDR_I,
  input  logic [31:0] HWDATA_I,
  output logic [31:0] HRDATA_O,
  output logic        HREADY_O,
  output logic        HRESP_O,
  output logic        TX_VALID_O,
  output logic [7:0]  TX_DATA_O,
  input  logic        TX_READY_I,
  output logic        EXIT_VALID_O,
  output logic [31:0] EXIT_CODE_O
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
  localparam logic [3:0]    NSCR    = 4'(NUM_SCRATCH);

  localparam logic [4:0] OFF_ID     = 5'd0;
  localparam logic [4:0] OFF_STATUS = 5'd1;
  localparam logic [4:0] OFF_TXDATA = 5'd2;
  localparam logic [4:0] OFF_EXIT   = 5'd3;
  localparam logic [4:0] OFF_CYC_LO = 5'd4;
  localparam logic [4:0] OFF_CYC_HI = 5'd5;

  // Registered state
  logic          r_dp_valid;
  logic          r_dp_write;
  logic [4:0]    r_dp_off;
  logic          r_hready;
  logic [31:0]   r_hrdata;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic          r_exit_valid;
  logic [31:0]   r_exit_code;
  logic [63:0]   r_cyc;
  logic [31:0]   r_cyc_hi;
  logic [31:0]   r_scratch [8];

  // Combinational next-state
  logic          w_accept;
  logic [4:0]    w_addr_off;
  logic          w_wr;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_level;
  logic          w_full;
  logic [PW-1:0] w_wr_ptr_n;
  logic [PW-1:0] w_rd_ptr_n;
  logic [PW-1:0] w_level_n;
  logic          w_dp_valid_n;
  logic          w_dp_write_n;
  logic [4:0]    w_dp_off_n;
  logic          w_hready_n;
  logic [7:0]    w_head_n;
  logic [31:0]   w_rdata;
  logic          w_scr_wr;
  logic          w_unused;

  assign w_unused = ^{HSIZE_I, HADDR_I[11:7], HADDR_I[1:0], HTRANS_I[0]};

  // Bus decode, FIFO bookkeeping and next data-phase state
  always_comb begin
    w_accept     = HSEL_I & HREADY_I & HTRANS_I[1];
    w_addr_off   = HADDR_I[6:2];
    // A data phase completes on any edge where we are driving ready high
    w_wr         = r_dp_valid & r_dp_write & r_hready;
    w_push       = w_wr & (r_dp_off == OFF_TXDATA);
    w_pop        = r_tx_valid & TX_READY_I;
    w_level      = r_wr_ptr - r_rd_ptr;
    w_full       = (w_level == DEPTH_P);
    w_wr_ptr_n   = r_wr_ptr + PW'(w_push);
    w_rd_ptr_n   = r_rd_ptr + PW'(w_pop);
    w_level_n    = w_wr_ptr_n - w_rd_ptr_n;
    w_scr_wr     = w_wr & (r_dp_off[4:3] == 2'b01) & ({1'b0, r_dp_off[2:0]} < NSCR);

    w_dp_valid_n = r_dp_valid;
    w_dp_write_n = r_dp_write;
    w_dp_off_n   = r_dp_off;
    if (w_accept) begin
      w_dp_valid_n = 1'b1;
      w_dp_write_n = HWRITE_I;
      w_dp_off_n   = w_addr_off;
    end else if (r_dp_valid & r_hready) begin
      w_dp_valid_n = 1'b0;
    end

    // Stall a TXDATA write data phase for as long as the FIFO will be full
    w_hready_n = ~(w_dp_valid_n & w_dp_write_n & (w_dp_off_n == OFF_TXDATA) &
                   (w_level_n == DEPTH_P));

    // Registered head: bypass when the pushed byte becomes the new head
    w_head_n = 8'h00;
    if (w_level_n != '0) begin
      if (w_push && (r_wr_ptr[AW-1:0] == w_rd_ptr_n[AW-1:0])) begin
        w_head_n = HWDATA_I[7:0];
      end else begin
        w_head_n = r_mem[w_rd_ptr_n[AW-1:0]];
      end
    end
  end

  // Read mux, evaluated in the address phase
  always_comb begin
    w_rdata = 32'h0;
    case (w_addr_off)
      OFF_ID:     w_rdata = ID_VALUE;
      OFF_STATUS: w_rdata = {16'h0, 8'(w_level), 6'h0, w_full, (w_level == '0)};
      OFF_CYC_LO: w_rdata = r_cyc[31:0];
      OFF_CYC_HI: w_rdata = r_cyc_hi;
      default: begin
        if ((w_addr_off[4:3] == 2'b01) && ({1'b0, w_addr_off[2:0]} < NSCR)) begin
          w_rdata = r_scratch[w_addr_off[2:0]];
        end
      end
    endcase
  end

  // FIFO storage, no reset needed
  always_ff @(posedge HCLK_I) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= HWDATA_I[7:0];
    end
  end

  // Control and register state
  always_ff @(posedge HCLK_I or negedge HRESET_N_I) begin
    if (!HRESET_N_I) begin
      r_dp_valid   <= 1'b0;
      r_dp_write   <= 1'b0;
      r_dp_off     <= 5'h0;
      r_hready     <= 1'b1;
      r_hrdata     <= 32'h0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_exit_valid <= 1'b0;
      r_exit_code  <= 32'h0;
      r_cyc        <= 64'h0;
      r_cyc_hi     <= 32'h0;
      for (int i = 0; i < 8; i++) begin
        r_scratch[i] <= 32'h0;
      end
    end else begin
      r_dp_valid <= w_dp_valid_n;
      r_dp_write <= w_dp_write_n;
      r_dp_off   <= w_dp_off_n;
      r_hready   <= w_hready_n;
      r_wr_ptr   <= w_wr_ptr_n;
      r_rd_ptr   <= w_rd_ptr_n;
      r_tx_valid <= (w_level_n != '0);
      r_tx_data  <= w_head_n;
      if (w_accept) begin
        r_hrdata <= HWRITE_I ? 32'h0 : w_rdata;
      end
      // Reading the low word snapshots the high word for a coherent 64-bit read
      if (w_accept && !HWRITE_I && (w_addr_off == OFF_CYC_LO)) begin
        r_cyc_hi <= r_cyc[63:32];
      end
      if (w_wr && (r_dp_off == OFF_CYC_LO)) begin
        r_cyc <= 64'h0;
      end else begin
        r_cyc <= r_cyc + 64'd1;
      end
      if (w_wr && (r_dp_off == OFF_EXIT) && !r_exit_valid) begin
        r_exit_valid <= 1'b1;
        r_exit_code  <= HWDATA_I;
      end
      if (w_scr_wr) begin
        r_scratch[r_dp_off[2:0]] <= HWDATA_I;
      end
    end
  end

  assign HRDATA_O     = r_hrdata;
  assign HREADY_O     = r_hready;
  assign HRESP_O      = 1'b0;
  assign TX_VALID_O   = r_tx_valid;
  assign TX_DATA_O    = r_tx_data;
  assign EXIT_VALID_O = r_exit_valid;
  assign EXIT_CODE_O  = r_exit_code;

endmodule
